// File: rtl/instr_fetch_ncl.sv
// Clocked instruction fetch feeding an NCL controller: reads 4-bit opcodes from a
// synchronous ROM and issues them as dual-rail DATA/NULL wavefronts under a 4-phase handshake.
module instr_fetch_ncl #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [3:0]  HALT_OPC    = 4'hF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [3:0]        mem_rdata,
    output logic [7:0]        instr_out,
    input  logic              ack_in,
    output logic              busy,
    output logic              halted,
    output logic [15:0]       issue_cnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_NULL  = 3'd4;
    localparam logic [2:0] S_HALT  = 3'd5;

    logic [2:0]             state;
    logic [ADDR_W-1:0]      pc;
    logic [3:0]             opcode;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;

    // Bit i maps to rails [2i+1] (true) and [2i] (false).
    function automatic logic [7:0] encode(input logic [3:0] d);
        logic [7:0] enc;
        enc = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            enc[2*i+1] = d[i];
            enc[2*i]   = ~d[i];
        end
        return enc;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_in};
        end
    end

    assign ack_s = ack_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pc        <= '0;
            opcode    <= '0;
            instr_out <= '0;
            issue_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !ack_s) state <= S_FETCH;
                end
                S_FETCH: state <= S_LOAD;
                S_LOAD: begin
                    instr_out <= encode(mem_rdata);
                    opcode    <= mem_rdata;
                    state     <= S_DATA;
                end
                S_DATA: begin
                    if (ack_s) begin
                        instr_out <= '0;
                        pc        <= pc + ADDR_W'(1);
                        state     <= S_NULL;
                    end
                end
                S_NULL: begin
                    if (!ack_s) begin
                        issue_cnt <= issue_cnt + 16'd1;
                        // Halt opcode wins over start so the program end is honoured.
                        if (opcode == HALT_OPC) state <= S_HALT;
                        else if (!start)        state <= S_IDLE;
                        else                    state <= S_FETCH;
                    end
                end
                S_HALT: instr_out <= '0;
                default: begin
                    instr_out <= '0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_addr  = pc;
    assign mem_rd_en = (state == S_FETCH);
    assign busy      = (state != S_IDLE) && (state != S_HALT);
    assign halted    = (state == S_HALT);

endmodule

// File: tb/tb_instr_fetch_ncl.sv
// Directed bench for instr_fetch_ncl: ROM/ack models plus a queue scoreboard of
// expected fetch addresses and DATA words, with a second small-address instance for pc wrap.
module tb_instr_fetch_ncl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  mem_addr;
    logic        mem_rd_en;
    logic [3:0]  mem_rdata = 4'h0;
    logic [7:0]  instr_out;
    logic        ack_in;
    logic        busy, halted;
    logic [15:0] issue_cnt;

    logic        start2;
    logic [1:0]  mem_addr2;
    logic        mem_rd_en2;
    logic [3:0]  mem_rdata2 = 4'h0;
    logic [7:0]  instr_out2;
    logic        ack2 = 1'b0;
    logic        busy2, halted2;
    logic [15:0] issue_cnt2;

    logic        ack_man  = 1'b0;
    logic        ack_auto = 1'b0;
    logic        auto_ack = 1'b0;
    logic [3:0]  rom  [256];
    logic [3:0]  rom2 [4];

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned rd2_cnt  = 0;
    logic [7:0]  exp_addr_q [$];
    logic [7:0]  exp_data_q [$];
    logic [7:0]  exp_addr2_q [$];
    logic [7:0]  exp_data2_q [$];
    logic [7:0]  prev_instr  = 8'h00;
    logic [7:0]  prev_instr2 = 8'h00;

    localparam int unsigned W_DATA   = 0;
    localparam int unsigned W_NULL   = 1;
    localparam int unsigned W_IDLE   = 2;
    localparam int unsigned W_HALT   = 3;
    localparam int unsigned W_RD2    = 4;
    localparam int unsigned W_IDLE2  = 5;

    assign ack_in = auto_ack ? ack_auto : ack_man;

    instr_fetch_ncl #(.ADDR_W(8), .SYNC_STAGES(2), .HALT_OPC(4'hF)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mem_addr(mem_addr),
        .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata), .instr_out(instr_out),
        .ack_in(ack_in), .busy(busy), .halted(halted), .issue_cnt(issue_cnt)
    );

    instr_fetch_ncl #(.ADDR_W(2), .SYNC_STAGES(2), .HALT_OPC(4'hF)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .mem_addr(mem_addr2),
        .mem_rd_en(mem_rd_en2), .mem_rdata(mem_rdata2), .instr_out(instr_out2),
        .ack_in(ack2), .busy(busy2), .halted(halted2), .issue_cnt(issue_cnt2)
    );

    initial forever #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (mem_rd_en)  mem_rdata  <= rom[mem_addr];
        if (mem_rd_en2) mem_rdata2 <= rom2[mem_addr2];
    end

    // Controller models: ack follows DATA/NULL on the wire one delta after each edge.
    always @(posedge clk) begin
        #1;
        ack_auto = (instr_out != 8'h00);
        ack2     = (instr_out2 != 8'h00);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (mem_rd_en) begin
                if (exp_addr_q.size() == 0) check("unexpected_read", 32'(mem_addr), 32'hFFFF);
                else check("fetch_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
            end
            if (instr_out != 8'h00 && prev_instr == 8'h00) begin
                check("dual_rail_legal", 32'((instr_out ^ (instr_out >> 1)) & 8'h55), 32'h55);
                if (exp_data_q.size() == 0) check("unexpected_data", 32'(instr_out), 32'h0);
                else check("data_word", 32'(instr_out), 32'(exp_data_q.pop_front()));
            end
            if (mem_rd_en2) begin
                rd2_cnt++;
                if (exp_addr2_q.size() == 0) check("unexpected_read2", 32'(mem_addr2), 32'hFFFF);
                else check("wrap_fetch_addr", 32'(mem_addr2), 32'(exp_addr2_q.pop_front()));
            end
            if (instr_out2 != 8'h00 && prev_instr2 == 8'h00) begin
                if (exp_data2_q.size() == 0) check("unexpected_data2", 32'(instr_out2), 32'h0);
                else check("wrap_data_word", 32'(instr_out2), 32'(exp_data2_q.pop_front()));
            end
        end
        prev_instr  = instr_out;
        prev_instr2 = instr_out2;
    end

    task automatic wait_for(input int unsigned sel, input int unsigned max_cycles, input string tag);
        logic ok;
        ok = 1'b0;
        for (int unsigned i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            case (sel)
                W_DATA:  ok = (instr_out != 8'h00);
                W_NULL:  ok = (instr_out == 8'h00);
                W_IDLE:  ok = !busy;
                W_HALT:  ok = halted;
                W_RD2:   ok = (rd2_cnt >= 5);
                W_IDLE2: ok = !busy2;
                default: ok = 1'b0;
            endcase
            if (ok) break;
        end
        check(tag, 32'(ok), 32'h1);
    endtask

    initial begin
        int unsigned k;
        for (int i = 0; i < 256; i++) rom[i] = 4'h0;
        for (int i = 0; i < 4; i++) rom2[i] = 4'h0;
        rom[0] = 4'hA;
        rom[1] = 4'hA;
        rom[2] = 4'h5;
        rst_n  = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;

        // Reset state
        #3;
        check("rst_instr", 32'(instr_out), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_addr", 32'(mem_addr), 32'h0);
        check("rst_rd_en", 32'(mem_rd_en), 32'h0);
        check("rst_issue", 32'(issue_cnt), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single fetch with exact latencies
        exp_addr_q.push_back(8'd0);
        exp_addr_q.push_back(8'd1);
        exp_data_q.push_back(8'h99);
        exp_data_q.push_back(8'h99);
        start = 1'b1;
        @(negedge clk);
        check("fetch_rd_en", 32'(mem_rd_en), 32'h1);
        check("fetch_addr0", 32'(mem_addr), 32'h0);
        @(negedge clk);
        check("load_rd_en", 32'(mem_rd_en), 32'h0);
        check("load_instr", 32'(instr_out), 32'h0);
        @(negedge clk);
        check("data_latency", 32'(instr_out), 32'h99);
        ack_man = 1'b1;
        k = 0;
        for (int unsigned i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (instr_out == 8'h00) begin
                k = i;
                break;
            end
        end
        check("ack_to_null_edges", k, 32'd3);
        check("pc_after_data", 32'(mem_addr), 32'h1);
        ack_man = 1'b0;
        repeat (3) @(negedge clk);
        check("next_fetch_rd_en", 32'(mem_rd_en), 32'h1);
        check("next_fetch_addr", 32'(mem_addr), 32'h1);
        check("issue_after_one", 32'(issue_cnt), 32'h1);

        // Slow ack: DATA must hold with no further reads
        wait_for(W_DATA, 10, "wait_data2");
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("slow_hold_instr", 32'(instr_out), 32'h99);
            check("slow_hold_pc", 32'(mem_addr), 32'h1);
            check("slow_no_rd", 32'(mem_rd_en), 32'h0);
        end

        // Stop during DATA: handshake completes, then idle
        start = 1'b0;
        ack_man = 1'b1;
        wait_for(W_NULL, 10, "wait_null2");
        ack_man = 1'b0;
        wait_for(W_IDLE, 10, "wait_idle_after_stop");
        check("stop_issue", 32'(issue_cnt), 32'h2);
        check("stop_pc", 32'(mem_addr), 32'h2);
        check("stop_halted", 32'(halted), 32'h0);

        // Stale ack holds IDLE
        ack_man = 1'b1;
        repeat (4) @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stale_no_rd", 32'(mem_rd_en), 32'h0);
            check("stale_idle", 32'(busy), 32'h0);
        end
        exp_addr_q.push_back(8'd2);
        exp_data_q.push_back(8'h66);
        ack_man = 1'b0;
        wait_for(W_DATA, 10, "wait_data_after_stale");
        check("pre_reset_instr", 32'(instr_out), 32'h66);

        // Asynchronous reset mid-DATA, checked before any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_instr", 32'(instr_out), 32'h0);
        check("async_rst_busy", 32'(busy), 32'h0);
        check("async_rst_pc", 32'(mem_addr), 32'h0);
        check("async_rst_issue", 32'(issue_cnt), 32'h0);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Halt program
        rom[0] = 4'h3;
        rom[1] = 4'hF;
        rom[2] = 4'h5;
        exp_addr_q.push_back(8'd0);
        exp_addr_q.push_back(8'd1);
        exp_data_q.push_back(8'h5A);
        exp_data_q.push_back(8'hAA);
        auto_ack = 1'b1;
        start = 1'b1;
        wait_for(W_HALT, 100, "wait_halt");
        check("halt_busy", 32'(busy), 32'h0);
        check("halt_pc", 32'(mem_addr), 32'h2);
        check("halt_issue", 32'(issue_cnt), 32'h2);
        check("halt_instr", 32'(instr_out), 32'h0);
        repeat (10) @(negedge clk);
        check("halt_sticky", 32'(halted), 32'h1);
        check("halt_null", 32'(instr_out), 32'h0);
        start = 1'b0;
        auto_ack = 1'b0;

        // pc wrap on the 2-bit instance
        for (int i = 0; i < 5; i++) exp_data2_q.push_back(8'h55);
        exp_addr2_q.push_back(8'd0);
        exp_addr2_q.push_back(8'd1);
        exp_addr2_q.push_back(8'd2);
        exp_addr2_q.push_back(8'd3);
        exp_addr2_q.push_back(8'd0);
        start2 = 1'b1;
        wait_for(W_RD2, 200, "wait_five_reads");
        start2 = 1'b0;
        wait_for(W_IDLE2, 50, "wait_wrap_idle");
        check("wrap_issue", 32'(issue_cnt2), 32'h5);
        check("wrap_pc", 32'(mem_addr2), 32'h1);
        repeat (5) @(negedge clk);

        check("addr_q_drained", exp_addr_q.size(), 32'h0);
        check("data_q_drained", exp_data_q.size(), 32'h0);
        check("addr2_q_drained", exp_addr2_q.size(), 32'h0);
        check("data2_q_drained", exp_data2_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_ncl.md
Name: instr_fetch_ncl

Overview:
- Clocked instruction-fetch stage directly upstream of the NCL controller.
- Reads 4-bit opcodes from a synchronous instruction ROM and encodes each as 4 dual-rail bits (8 wires).
- Runs the four-phase return-to-zero (DATA/NULL) handshake against the controller's asynchronous ack.
- Bridges the clocked program store into the self-timed datapath.

Parameters:
- ADDR_W, 8: program counter / ROM address width.
- SYNC_STAGES, 2: flops in the ack synchroniser, minimum 2.
- HALT_OPC, 4'hF: opcode that ends fetching once its handshake completes.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level; run fetching while high.
- mem_addr  out  ADDR_W  ROM address, equals pc.
- mem_rd_en  out  1  ROM read strobe.
- mem_rdata  in  4  ROM data, valid the cycle after the cycle mem_rd_en was high.
- instr_out  out  8  dual-rail opcode to controller: [2i+1]=bit i true rail, [2i]=bit i false rail.
- ack_in  in  1  controller ack, asynchronous. High = DATA captured; low = ready for next DATA.
- busy  out  1  high in any state except IDLE and HALT.
- halted  out  1  high in HALT.
- issue_cnt  out  16  count of completed DATA/NULL handshakes; wraps 16'hFFFF->0.

Behaviour:
- Reset (async, immediate):
  - instr_out=8'h00 (NULL), pc=0, mem_rd_en=0, busy=0, halted=0, issue_cnt=0, state=IDLE.
  - Synchroniser flops cleared to 0.
  - Mid-operation reset forces NULL at once; the controller is reset by the same rst_n.
- ack_s is ack_in passed through SYNC_STAGES flops. The FSM uses only ack_s.
- instr_out is driven directly from flops, so no combinational glitches reach the NCL stage. Legal values:
  - all zeros (NULL), or
  - exactly one rail high per bit pair (DATA).
  - Never both rails of a pair high.
- State IDLE:
  - If start=1 and ack_s=0, go to FETCH.
  - If start=1 and ack_s=1, stay in IDLE (stale ack).
- State FETCH: mem_rd_en=1 for exactly this cycle; mem_addr=pc. Next state LOAD.
- State LOAD:
  - mem_rdata valid; at the closing edge instr_out<=encode(mem_rdata). Next state DATA.
  - Latency: DATA appears 2 edges after the edge that sampled start.
- State DATA:
  - Hold instr_out until ack_s=1.
  - Then instr_out<=0, pc<=pc+1 (wraps 2^ADDR_W-1 -> 0), go to NULL.
- State NULL: wait for ack_s=0, then issue_cnt+1 and:
  - HALT, if the opcode just sent equals HALT_OPC (priority);
  - else IDLE, if start=0;
  - else FETCH.
- State HALT: outputs NULL, halted=1. Only reset leaves HALT; start is ignored.
- start falling during FETCH, LOAD or DATA does not abort: the current instruction completes its full DATA/NULL cycle first.
- ack_in toggling outside an expected phase (e.g. rising in FETCH) has no effect until the matching wait state.
- Implementation is one FSM plus pc, issue_cnt and synchroniser, roughly 150-250 lines.

Test Plan:
- Reset, no clocks: assert rst_n=0 mid-DATA with instr_out=8'h66 -> instr_out=0, busy=0, pc=0 immediately, before any clock edge.
- Single fetch: ROM[0]=4'hA, start=1, ack_in=0.
  - Expected: mem_rd_en pulses 1 cycle with mem_addr=0; instr_out=8'h99 two edges after start sampled.
  - Raise ack_in -> instr_out=0 after SYNC_STAGES+1 edges.
  - Drop ack_in -> issue_cnt=1 and next FETCH with mem_addr=1.
- Slow ack: hold ack_in low 50 cycles while in DATA -> instr_out stays 8'h99, pc unchanged, no mem_rd_en.
- Halt: ROM={4'h3, 4'hF, 4'h5}, ack model responding.
  - Expected outputs: 8'h5A, NULL, 8'hAA, NULL, then halted=1, pc=2, issue_cnt=2.
  - Address 2 is never read.
- Wrap: ADDR_W=2, ROM all 4'h0, run 5 handshakes -> mem_addr sequence 0,1,2,3,0; each DATA = 8'h55.
- Stale ack / stop: start=1 with ack_in=1 held -> stays IDLE, mem_rd_en=0. Release ack_in -> FETCH.
  - Drop start during DATA -> handshake completes, then IDLE with busy=0.
